// File: rtl/spi_to_usb_if.sv
// Signal bundle between the ADC-side/SPI-master world and the spi_to_usb transmitter.
interface spi_to_usb_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] data1;
    logic              new_Data;
    logic              SPI_clk;
    logic              cs;
    logic              MISO;

    modport master (output data1, output new_Data, output SPI_clk, output cs, input MISO);
    modport slave  (input data1, input new_Data, input SPI_clk, input cs, output MISO);
endinterface

// File: rtl/spi_to_usb.sv
// SPI mode-0 slave transmitter: latches ADC samples and shifts {fresh, seq, sample} out on MISO.
module spi_to_usb #(
    parameter int DATA_W      = 12,
    parameter int FRAME_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_to_usb_if.slave  bus
);
    localparam int CNT_W = $clog2(FRAME_W + 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   fill_q, fill_d;
    logic                   armed_q, armed_d;
    logic [DATA_W-1:0]      hold_q, hold_d;
    logic                   fresh_q, fresh_d;
    logic [2:0]             seq_q, seq_d;
    logic [FRAME_W-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   miso_q, miso_d;

    logic sclk_s, cs_s, sclk_fall, cs_fall, cs_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_fall = sclk_prev_q & ~sclk_s;
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign bus.MISO  = miso_q;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.SPI_clk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        fill_d      = 1'b1;
        // The synchroniser resets to "deselected"; only a genuinely sampled high cs
        // may arm frame loading, so cs held low through reset never starts a frame.
        armed_d     = armed_q | (fill_q & cs_sync_q[0]);
        hold_d      = hold_q;
        fresh_d     = fresh_q;
        seq_d       = seq_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        miso_d      = miso_q;

        if (cs_rise) begin
            miso_d = 1'b0;
            cnt_d  = '0;
        end else if (cs_fall && armed_q) begin
            shift_d = {fresh_q, seq_q, hold_q};
            miso_d  = fresh_q;
            fresh_d = 1'b0;
            cnt_d   = CNT_W'(1);
        end else if (sclk_fall && !cs_s && armed_q) begin
            if (cnt_q < CNT_W'(FRAME_W)) begin
                shift_d = shift_q << 1;
                miso_d  = shift_q[FRAME_W-2];
                cnt_d   = cnt_q + CNT_W'(1);
            end else begin
                miso_d = 1'b0;
            end
        end

        // A capture coinciding with a frame load overrides the flag cleared above.
        if (bus.new_Data) begin
            hold_d  = bus.data1;
            fresh_d = 1'b1;
            seq_d   = seq_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            fill_q      <= 1'b0;
            armed_q     <= 1'b0;
            hold_q      <= '0;
            fresh_q     <= 1'b0;
            seq_q       <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            miso_q      <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
            hold_q      <= hold_d;
            fresh_q     <= fresh_d;
            seq_q       <= seq_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            miso_q      <= miso_d;
        end
    end
endmodule

// File: tb/tb_spi_to_usb.sv
// Directed bench: acts as the SPI master (1 MHz, mode 0) and the ADC strobe source.
`timescale 1ns/100ps
module tb_spi_to_usb;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0] got;

    spi_to_usb_if #(.DATA_W(12)) bus ();

    spi_to_usb #(.DATA_W(12), .FRAME_W(16), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #62.5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_data(input logic [11:0] v);
        bus.data1    = v;
        bus.new_Data = 1'b1;
        #125;
        bus.new_Data = 1'b0;
        #125;
    endtask

    task automatic cs_low();
        bus.cs = 1'b0;
        #500;
    endtask

    task automatic cs_high();
        bus.cs = 1'b1;
        #1000;
    endtask

    // n SPI clock cycles; the master samples MISO on each rising edge.
    task automatic spi_bits(input int n, input int upd_at, input logic [11:0] upd_val,
                            output logic [31:0] res);
        res = '0;
        for (int i = 0; i < n; i++) begin
            bus.SPI_clk = 1'b1;
            res = {res[30:0], bus.MISO};
            if (i == upd_at) begin
                bus.data1    = upd_val;
                bus.new_Data = 1'b1;
                #125;
                bus.new_Data = 1'b0;
                #375;
            end else begin
                #500;
            end
            bus.SPI_clk = 1'b0;
            #500;
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        bus.cs       = 1'b0;
        bus.SPI_clk  = 1'b0;
        bus.new_Data = 1'b0;
        bus.data1    = '0;

        // Reset with cs low and SPI_clk toggling
        for (int i = 0; i < 2; i++) begin
            #25 bus.SPI_clk = 1'b1;
            #25 bus.SPI_clk = 1'b0;
        end
        check_val("reset_miso", {31'd0, bus.MISO}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // cs still low from reset: no frame may start
        pulse_data(12'hA5C);
        spi_bits(17, -1, 12'h0, got);
        check_val("no_frame_after_reset", got, 32'd0);
        cs_high();

        cs_low();
        spi_bits(16, -1, 12'h0, got);
        check_val("basic_frame", got, 32'h9A5C);
        cs_high();

        cs_low();
        spi_bits(16, -1, 12'h0, got);
        check_val("stale_reread", got, 32'h1A5C);
        cs_high();

        pulse_data(12'h001);
        cs_low();
        spi_bits(16, -1, 12'h0, got);
        check_val("third_sample", got, 32'hA001);
        cs_high();

        // Sequence wrap: 8 captures after reset
        rst = 1'b1;
        #100;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) pulse_data(12'hFFF);
        cs_low();
        spi_bits(16, -1, 12'h0, got);
        check_val("seq_wrap", got, 32'h8FFF);
        cs_high();

        // Mid-frame capture leaves the in-flight frame alone
        pulse_data(12'hA5C);
        pulse_data(12'hA5C);
        cs_low();
        spi_bits(16, 5, 12'h123, got);
        check_val("midframe_current", got, 32'hAA5C);
        cs_high();
        cs_low();
        spi_bits(16, -1, 12'h0, got);
        check_val("midframe_next", got, 32'hB123);
        cs_high();

        // Abort after 7 bits of 0x3123; the 8th bit (1) is already on MISO
        cs_low();
        spi_bits(7, -1, 12'h0, got);
        check_val("abort_bits", got, 32'h18);
        check_val("abort_pending_bit", {31'd0, bus.MISO}, 32'd1);
        bus.cs = 1'b1;
        #500;
        check_val("abort_miso_cleared", {31'd0, bus.MISO}, 32'd0);
        #500;
        cs_low();
        spi_bits(16, -1, 12'h0, got);
        check_val("after_abort", got, 32'h3123);
        cs_high();

        // Overrun: 20 clocks in one frame
        cs_low();
        spi_bits(20, -1, 12'h0, got);
        check_val("overrun", got, 32'h31230);
        cs_high();

        // Async reset mid-frame
        pulse_data(12'hFFF);
        cs_low();
        check_val("frame_msb_loaded", {31'd0, bus.MISO}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("async_rst_miso", {31'd0, bus.MISO}, 32'd0);
        #99;
        rst = 1'b0;
        @(negedge clk);
        pulse_data(12'h555);
        spi_bits(4, -1, 12'h0, got);
        check_val("no_frame_after_midrst", got, 32'd0);
        cs_high();
        cs_low();
        spi_bits(16, -1, 12'h0, got);
        check_val("frame_after_midrst", got, 32'h9555);
        cs_high();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
